memory_test_client: RTL and testbench
=====================================

Name: memory_test_client

Overview:
- Initiator for the single-port shared-memory interface: address, readWrite (1 = read, 0 = write), dataIn, enabled, plus registered dataOut with 1-cycle read latency.
- On a start pulse it requests the memory from the arbiter, writes a seeded incrementing pattern over a contiguous, wrapping address range, reads the range back and checks it. It then reports pass/fail, the error count and the first failing address.
- Used as a bus-traffic generator and self-check client behind the arbiter.

Parameters:
ADDR_WIDTH, 8, memory address width; also the width of length.
DATA_WIDTH, 32, memory word width.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; sampled only in IDLE
baseAddr  input  ADDR_WIDTH  first address of the range; sampled with start
length  input  ADDR_WIDTH  words minus 1 (N = length+1, 1..256); sampled with start
seed  input  DATA_WIDTH  pattern base value; sampled with start
busy  output  1  high from the start edge until DONE is left
done  output  1  one-cycle pulse at end of run
pass  output  1  1 if errorCount == 0; valid from done, held until next start
errorCount  output  ADDR_WIDTH+1  number of mismatching words
firstErrAddr  output  ADDR_WIDTH  address of the first mismatch; 0 if none
request  output  1  arbiter request
grant  input  1  arbiter grant; may drop at any cycle
memAddress  output  ADDR_WIDTH  to memory address
memReadWrite  output  1  to memory readWrite
memDataIn  output  DATA_WIDTH  to memory dataIn
memDataOut  input  DATA_WIDTH  from memory dataOut (registered, 1-cycle latency)
memEnabled  output  1  to memory enabled

Behaviour:
- Reset: state IDLE; busy, done, pass, errorCount, firstErrAddr, request all 0; index 0; pending-check flag cleared. Reset mid-run aborts immediately: request drops in the cycle after the reset edge and no memory access is issued.
- States and transitions:
  - IDLE: start → REQ. Latch baseAddr, length and seed; clear errorCount, firstErrAddr and pass; set busy.
  - REQ: request=1. grant → WRITE with index=0.
  - WRITE: each cycle with grant, issue write, then index++. After the write at index==length → READ with index=0.
  - READ: each cycle with grant, issue read, then index++. After the read at index==length → DRAIN.
  - DRAIN: complete the final compare → DONE.
  - DONE: done=1 for one cycle, pass=(errorCount==0), busy=0 → IDLE.
- request is high in REQ, WRITE, READ and DRAIN. It is released in DONE.
- Memory drive:
  - memEnabled = grant && state in {WRITE, READ} (combinational). Access is never issued without grant.
  - memAddress = (latched baseAddr + index) mod 2^ADDR_WIDTH, so the range wraps past 0xFF.
  - memDataIn = (seed + index) mod 2^DATA_WIDTH.
  - memReadWrite = 1 in READ/DRAIN, 0 in WRITE, 1 otherwise.
- Grant loss: index holds and no access is issued; the run resumes when grant returns. A read issued on the preceding cycle is still compared on the next edge regardless of grant.
- Check pipeline: an edge where a read is issued sets pending=1 and registers expected = seed+index and addr. On the next edge, if pending, compare memDataOut with expected. On mismatch, errorCount++; if this is the first mismatch, set firstErrAddr = addr.
- start while busy is ignored. start coincident with rst is ignored.
- Latency with grant held high: done is high after rising edge 2N+3 counted from the start edge (edge 1 = start sampled). For N=4 that is edge 11.

Decomposition:
- Package memory_client_pkg: state enum (IDLE, REQ, WRITE, READ, DRAIN, DONE), ADDR_WIDTH/DATA_WIDTH defaults, pattern function (seed, index).
- Sub-module memory_read_checker: pending flag, expected/addr registers, compare, errorCount, firstErrAddr. Interface: issue strobe, expected, addr, memDataOut, clear.

Test Plan:
- baseAddr=0x10, length=3, seed=0xA5A50000, grant tied 1, clean memory model → writes 0x10..0x13 = 0xA5A50000..0xA5A50003, then 4 reads; done at edge 11; pass=1, errorCount=0, firstErrAddr=0.
- baseAddr=0xFE, length=3, seed=0xFFFFFFFE → addresses 0xFE, 0xFF, 0x00, 0x01; data 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001; pass=1.
- Model corrupts the reads at 0x12 and 0x13 (run 1 setup) → errorCount=2, firstErrAddr=0x12, pass=0.
- length=255, baseAddr=0x80, grant toggled 1-on/1-off → all 256 words written and read once; memEnabled never high while grant=0; pass=1; errorCount is 9 bits wide, no overflow.
- Grant dropped for 5 cycles immediately after a read is issued → that read is still compared; index frozen; run completes with pass=1.
- rst asserted mid-WRITE → next cycle request=0, memEnabled=0, busy=0; a new start runs to completion normally; start pulsed while busy has no effect.

Source files
------------

// File: rtl/memory_client_pkg.sv
// Shared types and helpers for the memory test client: FSM states, default widths
// and the write/read-back pattern generator.
package memory_client_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int PAT_W      = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  // Wide enough for any supported data width; callers truncate to their word size.
  function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] seed,
                                               input logic [PAT_W-1:0] idx);
    return seed + idx;
  endfunction

endpackage

// File: rtl/memory_test_client_checker.sv
// Read-back checker: holds one outstanding read, compares it against the expected
// pattern on the following edge and accumulates mismatch statistics.
module memory_read_checker
  import memory_client_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_W,
  parameter int DATA_WIDTH = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  issue,
  input  logic [DATA_WIDTH-1:0] expected,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] memDataOut,
  output logic                  mismatch,
  output logic [ADDR_WIDTH:0]   errorCount,
  output logic [ADDR_WIDTH-1:0] firstErrAddr
);

  logic                  pending_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;

  always_comb begin
    mismatch  = pending_q && (memDataOut != exp_q);
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    if (mismatch) begin
      err_cnt_d = err_cnt_q + (ADDR_WIDTH+1)'(1);
      if (err_cnt_q == '0) first_d = addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pending_q <= 1'b0;
      err_cnt_q <= '0;
      first_q   <= '0;
    end else begin
      pending_q <= issue;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
    end
  end

  // Captured read context is pure data and qualified by pending_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (issue) begin
      exp_q  <= expected;
      addr_q <= addr;
    end
  end

  assign errorCount   = err_cnt_q;
  assign firstErrAddr = first_q;

endmodule

// File: rtl/memory_test_client.sv
// Shared-memory initiator: on start, writes a seeded incrementing pattern over a
// wrapping address range, reads it back and reports pass/fail statistics.
module memory_test_client
  import memory_client_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_W,
  parameter int DATA_WIDTH = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] baseAddr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   errorCount,
  output logic [ADDR_WIDTH-1:0] firstErrAddr,
  output logic                  request,
  input  logic                  grant,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic                  memReadWrite,
  output logic [DATA_WIDTH-1:0] memDataIn,
  input  logic [DATA_WIDTH-1:0] memDataOut,
  output logic                  memEnabled
);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic                  busy_q, done_q, pass_q, request_q;
  logic                  accept;
  logic                  rd_issue;
  logic                  chk_mismatch;

  assign accept       = (state_q == S_IDLE) && start;
  assign memEnabled   = grant && ((state_q == S_WRITE) || (state_q == S_READ));
  assign rd_issue     = memEnabled && (state_q == S_READ);
  assign memAddress   = base_q + idx_q;
  assign memDataIn    = DATA_WIDTH'(pattern(PAT_W'(seed_q), PAT_W'(idx_q)));
  assign memReadWrite = (state_q != S_WRITE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      request_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q    <= baseAddr;
            len_q     <= length;
            seed_q    <= seed;
            pass_q    <= 1'b0;
            busy_q    <= 1'b1;
            request_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (grant) begin
            idx_q   <= '0;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (grant) begin
            if (idx_q == len_q) begin
              idx_q   <= '0;
              state_q <= S_READ;
            end else begin
              idx_q <= idx_q + ADDR_WIDTH'(1);
            end
          end
        end
        S_READ: begin
          if (grant) begin
            if (idx_q == len_q) state_q <= S_DRAIN;
            else                idx_q   <= idx_q + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          // The last read is compared on this same edge, so fold its outcome in directly.
          pass_q    <= (errorCount == '0) && !chk_mismatch;
          done_q    <= 1'b1;
          request_q <= 1'b0;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  memory_read_checker #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_checker (
    .clk         (clk),
    .rst         (rst),
    .clear       (accept),
    .issue       (rd_issue),
    .expected    (memDataIn),
    .addr        (memAddress),
    .memDataOut  (memDataOut),
    .mismatch    (chk_mismatch),
    .errorCount  (errorCount),
    .firstErrAddr(firstErrAddr)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign request = request_q;

endmodule

// File: tb/tb_memory_test_client.sv
// Scoreboard bench for memory_test_client: a behavioural memory with fault injection,
// a grant driver with several patterns, and queue-based access/result checking.
module tb_memory_test_client;

  typedef struct {
    logic        rw;
    logic [7:0]  a;
    logic [31:0] d;
  } acc_t;

  typedef struct {
    logic       p;
    logic [8:0] ec;
    logic [7:0] fa;
    int         lat;
  } res_t;

  logic        clk = 1'b0;
  logic        rst, start, grant;
  logic [7:0]  baseAddr, length;
  logic [31:0] seed;
  logic        busy, done, pass, request;
  logic [8:0]  errorCount;
  logic [7:0]  firstErrAddr, memAddress;
  logic        memReadWrite, memEnabled;
  logic [31:0] memDataIn, memDataOut;

  logic [31:0] mem [0:255];
  bit          corrupt [0:255];
  acc_t        exp_acc[$];
  res_t        exp_res[$];

  int errors = 0, checks = 0;
  int cyc = 0, start_edge = 0, done_cnt = 0, rd_cnt = 0;
  int gmode = 0, drop_cnt = 0;
  bit dropped = 0, rd_last = 0;

  memory_test_client dut (
    .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr), .length(length),
    .seed(seed), .busy(busy), .done(done), .pass(pass), .errorCount(errorCount),
    .firstErrAddr(firstErrAddr), .request(request), .grant(grant),
    .memAddress(memAddress), .memReadWrite(memReadWrite), .memDataIn(memDataIn),
    .memDataOut(memDataOut), .memEnabled(memEnabled)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memory with registered read data; flagged addresses read back corrupted.
  always @(posedge clk) begin
    if (memEnabled) begin
      if (!memReadWrite) mem[memAddress] <= memDataIn;
      else memDataOut <= mem[memAddress] ^ (corrupt[memAddress] ? 32'h0000_0100 : 32'h0);
    end
  end

  // Grant patterns: 0 tied high, 1 toggling, 2 random, 3 five-cycle drop after the second read.
  initial begin
    grant = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (gmode)
        1: grant = ~grant;
        2: grant = 1'($urandom_range(0, 1));
        3: begin
          if (drop_cnt > 0) begin
            grant = 1'b0;
            drop_cnt--;
          end else if (rd_last && rd_cnt == 2 && !dropped) begin
            dropped  = 1'b1;
            grant    = 1'b0;
            drop_cnt = 4;
          end else grant = 1'b1;
        end
        default: grant = 1'b1;
      endcase
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expected access per enabled cycle and one result per done pulse.
  always @(negedge clk) begin
    acc_t e;
    res_t r;
    rd_last = memEnabled && memReadWrite;
    if (memEnabled) begin
      chk("grant_during_access", grant, 1);
      if (memReadWrite) rd_cnt++;
      if (exp_acc.size() == 0) chk("unexpected_access", 1, 0);
      else begin
        e = exp_acc.pop_front();
        chk("access_rw", memReadWrite, e.rw);
        chk("access_addr", memAddress, e.a);
        if (!e.rw) chk("write_data", memDataIn, e.d);
      end
    end
    if (done) begin
      done_cnt++;
      if (exp_res.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        r = exp_res.pop_front();
        chk("pass", pass, r.p);
        chk("errorCount", errorCount, r.ec);
        chk("firstErrAddr", firstErrAddr, r.fa);
        if (r.lat >= 0) chk("done_latency", cyc - start_edge + 1, r.lat);
      end
    end
  end

  task automatic start_run(input logic [7:0] b, input logic [7:0] l, input logic [31:0] s,
                           input int gm, input bit lat);
    acc_t a;
    res_t r;
    int   n, ec;
    n = int'(l) + 1;
    ec = 0;
    r.fa = 8'h00;
    for (int i = 0; i < n; i++) begin
      a.rw = 1'b0; a.a = b + 8'(i); a.d = s + 32'(i);
      exp_acc.push_back(a);
    end
    for (int i = 0; i < n; i++) begin
      a.rw = 1'b1; a.a = b + 8'(i); a.d = s + 32'(i);
      exp_acc.push_back(a);
      if (corrupt[a.a]) begin
        if (ec == 0) r.fa = a.a;
        ec++;
      end
    end
    r.ec  = 9'(ec);
    r.p   = (ec == 0);
    r.lat = lat ? 2 * n + 3 : -1;
    exp_res.push_back(r);
    gmode   = gm;
    dropped = 1'b0;
    rd_cnt  = 0;
    @(posedge clk); #1;
    baseAddr = b; length = l; seed = s; start = 1'b1;
    @(posedge clk); #1;
    start_edge = cyc;
    start = 1'b0; baseAddr = ~b; length = 8'($urandom); seed = $urandom;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input bit poke);
    int n0;
    n0 = done_cnt;
    if (poke) begin
      repeat (4) @(posedge clk);
      #1; start = 1'b1; baseAddr = 8'h33; length = 8'h00; seed = 32'h0;
      @(posedge clk); #1; start = 1'b0;
    end
    for (int k = 0; k < 3000 && done_cnt == n0; k++) @(posedge clk);
    if (done_cnt == n0) begin
      chk("done_timeout", 0, 1);
      exp_acc.delete();
      exp_res.delete();
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
    end
    chk("accesses_all_seen", exp_acc.size(), 0);
    gmode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("request_after_done", request, 0);
  endtask

  task automatic run(input logic [7:0] b, input logic [7:0] l, input logic [31:0] s,
                     input int gm, input bit lat, input bit poke);
    start_run(b, l, s, gm, lat);
    wait_done(poke);
  endtask

  initial begin
    logic [7:0] rb, rl;
    rst = 1'b1; start = 1'b0; baseAddr = '0; length = '0; seed = '0;
    for (int i = 0; i < 256; i++) corrupt[i] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_errorCount", errorCount, 0);
    chk("rst_firstErrAddr", firstErrAddr, 0);
    chk("rst_request", request, 0);
    #1 rst = 1'b0;

    run(8'h10, 8'd3, 32'hA5A5_0000, 0, 1, 0);
    run(8'hFE, 8'd3, 32'hFFFF_FFFE, 0, 1, 0);
    corrupt[8'h12] = 1'b1; corrupt[8'h13] = 1'b1;
    run(8'h10, 8'd3, 32'hA5A5_0000, 0, 1, 0);
    chk("pass_held_after_done", pass, 0);
    corrupt[8'h12] = 1'b0; corrupt[8'h13] = 1'b0;
    run(8'h80, 8'd255, $urandom, 1, 0, 0);

    corrupt[8'h41] = 1'b1;
    run(8'h40, 8'd7, 32'h1234_5678, 3, 0, 0);
    corrupt[8'h41] = 1'b0;

    for (int i = 0; i < 256; i++) corrupt[i] = 1'b1;
    run(8'hC3, 8'd255, 32'h0BAD_F00D, 0, 1, 0);
    for (int i = 0; i < 256; i++) corrupt[i] = 1'b0;

    run(8'h20, 8'd9, 32'h0000_1000, 0, 1, 1);

    // Abort mid-write, then confirm the bus is quiet and a fresh run still works.
    start_run(8'h50, 8'd15, 32'hDEAD_0000, 0, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_request", request, 0);
    chk("abort_memEnabled", memEnabled, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    exp_acc.delete();
    exp_res.delete();
    repeat (3) @(negedge clk) chk("abort_quiet", memEnabled, 0);
    run(8'h50, 8'd15, 32'hDEAD_0000, 0, 1, 0);

    @(posedge clk); #1; rst = 1'b1; start = 1'b1;
    @(posedge clk); #1; rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_with_rst_busy", busy, 0);
    chk("start_with_rst_request", request, 0);

    for (int t = 0; t < 5; t++) begin
      rb = 8'($urandom);
      rl = 8'($urandom_range(0, 40));
      for (int k = 0; k < 3; k++) corrupt[8'(rb + 8'($urandom_range(0, int'(rl))))] = 1'b1;
      run(rb, rl, $urandom, (t % 3), (t % 3) == 0, 0);
      for (int i = 0; i < 256; i++) corrupt[i] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
